// File: rtl/tabela_tiros.sv
// Shot table: valid bitmap, lowest-free allocation with ack/nack, release, in-place update, registered read, sequential scan.
// Defining TABELA_TIROS_OCUPACAO_EN adds a registered valid-slot counter on ocupacao; otherwise ocupacao is tied to 0.
module tabela_tiros #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              aloca_req,
   input  logic [DATA_W-1:0] aloca_dado,
   output logic              aloca_ack,
   output logic              aloca_nack,
   output logic [AW-1:0]     aloca_idx,
   output logic              cheio,
   input  logic              libera,
   input  logic [AW-1:0]     libera_idx,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              varre_inicio,
   output logic              varre_ocupado,
   output logic              varre_valido,
   output logic [AW-1:0]     varre_idx,
   output logic [DATA_W-1:0] varre_dado,
   output logic              varre_fim,
   output logic [AW:0]       ocupacao
);
   typedef enum logic [1:0] {OCIOSO, VARRE, FIM} estado_t;

   logic [DATA_W-1:0] ram_q [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [AW-1:0]     rd_addr_q;
   logic              ack_q, nack_q;
   logic [AW-1:0]     aloca_idx_q;
   logic [AW-1:0]     livre_idx;
   logic              aloca_ok, wr_ok, libera_ok;

   estado_t           estado_q, estado_d;
   logic [AW-1:0]     ptr_q, ptr_d, vidx_q, vidx_d;
   logic [DATA_W-1:0] vdado_q, vdado_d;
   logic              vval_q, vval_d, vocup_q, vocup_d, vfim_q, vfim_d;

   assign cheio     = &valid_q;
   assign aloca_ok  = aloca_req & ~cheio;
   assign wr_ok     = wr_en & valid_q[wr_addr];
   assign libera_ok = libera & valid_q[libera_idx];

   // Downward walk so the lowest free index is the last one written.
   always_comb begin
      livre_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) livre_idx = AW'(i);
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (libera_ok) valid_d[libera_idx] = 1'b0;
      if (aloca_ok)  valid_d[livre_idx]  = 1'b1;
   end

   // Data array has no reset; an allocated slot and an updated slot can never coincide.
   always_ff @(posedge clk) begin
      if (aloca_ok) ram_q[livre_idx] <= aloca_dado;
      if (wr_ok)    ram_q[wr_addr]   <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= '0;
         rd_addr_q   <= '0;
         ack_q       <= 1'b0;
         nack_q      <= 1'b0;
         aloca_idx_q <= '0;
      end else begin
         valid_q   <= valid_d;
         rd_addr_q <= rd_addr;
         ack_q     <= aloca_ok;
         nack_q    <= aloca_req & cheio;
         if (aloca_ok) aloca_idx_q <= livre_idx;
      end
   end

   assign aloca_ack  = ack_q;
   assign aloca_nack = nack_q;
   assign aloca_idx  = aloca_idx_q;
   assign rd_data    = ram_q[rd_addr_q];
   assign rd_valid   = valid_q[rd_addr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         ptr_q    <= '0;
         vidx_q   <= '0;
         vdado_q  <= '0;
         vval_q   <= 1'b0;
         vocup_q  <= 1'b0;
         vfim_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         ptr_q    <= ptr_d;
         vidx_q   <= vidx_d;
         vdado_q  <= vdado_d;
         vval_q   <= vval_d;
         vocup_q  <= vocup_d;
         vfim_q   <= vfim_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      ptr_d    = ptr_q;
      vidx_d   = vidx_q;
      vdado_d  = vdado_q;
      vval_d   = vval_q;
      vocup_d  = vocup_q;
      vfim_d   = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            if (varre_inicio) begin
               estado_d = VARRE;
               ptr_d    = '0;
               vocup_d  = 1'b1;
            end
         end
         VARRE: begin
            vidx_d  = ptr_q;
            vdado_d = ram_q[ptr_q];
            vval_d  = valid_q[ptr_q];
            ptr_d   = ptr_q + 1'b1;
            if (ptr_q == AW'(DEPTH - 1)) estado_d = FIM;
         end
         FIM: begin
            vfim_d   = 1'b1;
            vval_d   = 1'b0;
            vocup_d  = 1'b0;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   assign varre_ocupado = vocup_q;
   assign varre_valido  = vval_q;
   assign varre_idx     = vidx_q;
   assign varre_dado    = vdado_q;
   assign varre_fim     = vfim_q;

`ifdef TABELA_TIROS_OCUPACAO_EN
   logic [AW:0] ocup_q;

   // A granted slot is always free, so a same-cycle alloc and release never hit the same slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ocup_q <= '0;
      end else if (aloca_ok && !libera_ok) begin
         ocup_q <= ocup_q + 1'b1;
      end else if (libera_ok && !aloca_ok) begin
         ocup_q <= ocup_q - 1'b1;
      end
   end

   assign ocupacao = ocup_q;
`else
   assign ocupacao = '0;
`endif

endmodule

// File: tb/tb_tabela_tiros.sv
// Self-checking bench for tabela_tiros: directed vector table, hand sequences for full-table, scan and mid-scan reset,
// then randomized traffic against a slot-level reference model.
module tb_tabela_tiros;
   localparam int DW = 10;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          aloca_req = 1'b0;
   logic [DW-1:0] aloca_dado = '0;
   logic          aloca_ack, aloca_nack, cheio;
   logic [AW-1:0] aloca_idx;
   logic          libera = 1'b0;
   logic [AW-1:0] libera_idx = '0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          varre_inicio = 1'b0;
   logic          varre_ocupado, varre_valido, varre_fim;
   logic [AW-1:0] varre_idx;
   logic [DW-1:0] varre_dado;
   logic [AW:0]   ocupacao;

   tabela_tiros #(.DATA_W(DW), .DEPTH(D), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .aloca_req(aloca_req), .aloca_dado(aloca_dado), .aloca_ack(aloca_ack),
      .aloca_nack(aloca_nack), .aloca_idx(aloca_idx), .cheio(cheio),
      .libera(libera), .libera_idx(libera_idx),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .varre_inicio(varre_inicio), .varre_ocupado(varre_ocupado), .varre_valido(varre_valido),
      .varre_idx(varre_idx), .varre_dado(varre_dado), .varre_fim(varre_fim),
      .ocupacao(ocupacao)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: slot state plus expected registered outputs.
   bit [D-1:0]    m_valid;
   logic [DW-1:0] m_ram [D];
   logic          e_ack, e_nack;
   logic [AW-1:0] e_idx, e_rd_addr;
   int            sc;
   logic [AW-1:0] e_vidx;
   logic [DW-1:0] e_vdado;
   logic          e_vval, e_vocup, e_vfim;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int occ_of(input int n);
`ifdef TABELA_TIROS_OCUPACAO_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic model_reset();
      m_valid   = '0;
      e_ack     = 1'b0;
      e_nack    = 1'b0;
      e_idx     = '0;
      e_rd_addr = '0;
      sc        = -1;
      e_vidx    = '0;
      e_vdado   = '0;
      e_vval    = 1'b0;
      e_vocup   = 1'b0;
      e_vfim    = 1'b0;
   endtask

   task automatic model_edge();
      bit [D-1:0]    pv;
      logic [DW-1:0] pram [D];
      int            slot;
      pv   = m_valid;
      pram = m_ram;
      slot = -1;
      for (int i = D - 1; i >= 0; i--) if (!pv[i]) slot = i;
      e_ack  = 1'b0;
      e_nack = 1'b0;
      if (aloca_req) begin
         if (slot >= 0) begin
            m_ram[slot]   = aloca_dado;
            m_valid[slot] = 1'b1;
            e_ack = 1'b1;
            e_idx = AW'(slot);
         end else begin
            e_nack = 1'b1;
         end
      end
      if (libera && pv[libera_idx]) m_valid[libera_idx] = 1'b0;
      if (wr_en && pv[wr_addr]) m_ram[wr_addr] = wr_data;
      e_rd_addr = rd_addr;
      // sc counts edges since the scan start: 0..D-1 visit slot sc, D is the end-pulse edge.
      e_vfim = 1'b0;
      if (sc < 0) begin
         if (varre_inicio) begin
            sc = 0;
            e_vocup = 1'b1;
         end
      end else if (sc < D) begin
         e_vidx  = AW'(sc);
         e_vdado = pram[sc];
         e_vval  = pv[sc];
         sc++;
      end else begin
         e_vfim  = 1'b1;
         e_vval  = 1'b0;
         e_vocup = 1'b0;
         sc      = -1;
      end
   endtask

   task automatic check_all();
      chk("aloca_ack", 32'(aloca_ack), 32'(e_ack));
      chk("aloca_nack", 32'(aloca_nack), 32'(e_nack));
      if (e_ack) chk("aloca_idx", 32'(aloca_idx), 32'(e_idx));
      chk("cheio", 32'(cheio), 32'(&m_valid));
      chk("rd_valid", 32'(rd_valid), 32'(m_valid[e_rd_addr]));
      if (m_valid[e_rd_addr]) chk("rd_data", 32'(rd_data), 32'(m_ram[e_rd_addr]));
      chk("varre_ocupado", 32'(varre_ocupado), 32'(e_vocup));
      chk("varre_fim", 32'(varre_fim), 32'(e_vfim));
      chk("varre_valido", 32'(varre_valido), 32'(e_vval));
      chk("varre_idx", 32'(varre_idx), 32'(e_vidx));
      if (e_vval) chk("varre_dado", 32'(varre_dado), 32'(e_vdado));
      chk("ocupacao", 32'(ocupacao), 32'(occ_of($countones(m_valid))));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      aloca_req    = 1'b0;
      libera       = 1'b0;
      wr_en        = 1'b0;
      varre_inicio = 1'b0;
   endtask

   typedef struct {
      bit            req;
      logic [DW-1:0] dado;
      bit            lib;
      logic [AW-1:0] li;
      bit            wr;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [AW-1:0] ra;
      bit            ack;
      logic [AW-1:0] idx;
      bit            rv;
      logic [DW-1:0] rdat;
      int            occ;
   } vec_t;

   vec_t tv [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, nfim;
      logic [D-1:0] seen;

      //        req dado     lib li wr wa wd      ra  ack idx rv rdat     occ
      tv[0] = '{1, 10'h1C0, 0, 0, 0, 0, 10'h0,  0,  1,  0,  1, 10'h1C0, 1};
      tv[1] = '{1, 10'h002, 0, 0, 0, 0, 10'h0,  1,  1,  1,  1, 10'h002, 2};
      tv[2] = '{1, 10'h001, 0, 0, 0, 0, 10'h0,  1,  1,  2,  1, 10'h002, 3};
      tv[3] = '{0, 10'h000, 1, 1, 0, 0, 10'h0,  1,  0,  0,  0, 10'h000, 2};
      tv[4] = '{1, 10'h05C, 0, 0, 0, 0, 10'h0,  1,  1,  1,  1, 10'h05C, 3};
      tv[5] = '{0, 10'h000, 0, 0, 1, 9, 10'h3FF, 9, 0,  0,  0, 10'h000, 3};
      tv[6] = '{0, 10'h000, 0, 0, 1, 0, 10'h0AA, 0, 0,  0,  1, 10'h0AA, 3};

      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      reset = 1'b0;

      for (int k = 0; k < 7; k++) begin
         aloca_req  = tv[k].req;
         aloca_dado = tv[k].dado;
         libera     = tv[k].lib;
         libera_idx = tv[k].li;
         wr_en      = tv[k].wr;
         wr_addr    = tv[k].wa;
         wr_data    = tv[k].wd;
         rd_addr    = tv[k].ra;
         tick();
         chk($sformatf("vec%0d ack", k), 32'(aloca_ack), 32'(tv[k].ack));
         if (tv[k].ack) chk($sformatf("vec%0d idx", k), 32'(aloca_idx), 32'(tv[k].idx));
         chk($sformatf("vec%0d rd_valid", k), 32'(rd_valid), 32'(tv[k].rv));
         if (tv[k].rv) chk($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(tv[k].rdat));
         chk($sformatf("vec%0d ocupacao", k), 32'(ocupacao), 32'(occ_of(tv[k].occ)));
         idle();
      end

      // Fill remaining slots 3..15 with a held request.
      for (int i = 3; i < D; i++) begin
         aloca_req  = 1'b1;
         aloca_dado = 10'(i * 37);
         tick();
      end
      chk("fill last idx", 32'(aloca_idx), 32'd15);
      tick();
      chk("full nack", 32'(aloca_nack), 32'd1);
      chk("full cheio", 32'(cheio), 32'd1);
      libera     = 1'b1;
      libera_idx = 4'd7;
      rd_addr    = 4'd7;
      tick();
      chk("full+rel nack", 32'(aloca_nack), 32'd1);
      chk("full+rel cheio", 32'(cheio), 32'd0);
      chk("full+rel rd_valid", 32'(rd_valid), 32'd0);
      chk("full+rel ocupacao", 32'(ocupacao), 32'(occ_of(15)));
      libera = 1'b0;
      tick();
      chk("refill idx", 32'(aloca_idx), 32'd7);
      chk("refill ack", 32'(aloca_ack), 32'd1);
      idle();

      // Leave only slots 0, 2, 15 valid, then scan.
      for (int i = 1; i < 15; i++) begin
         if (i != 2) begin
            libera     = 1'b1;
            libera_idx = AW'(i);
            tick();
         end
      end
      idle();
      varre_inicio = 1'b1;
      tick();
      varre_inicio = 1'b0;
      chk("scan ocupado", 32'(varre_ocupado), 32'd1);
      nv = 0;
      nfim = 0;
      seen = '0;
      for (int c = 0; c < 20; c++) begin
         varre_inicio = (c == 7);
         tick();
         if (varre_valido) begin
            nv++;
            seen[varre_idx] = 1'b1;
            if (varre_idx == 4'd2) chk("scan dado slot2", 32'(varre_dado), 32'h001);
            if (varre_idx == 4'd0) chk("scan dado slot0", 32'(varre_dado), 32'h0AA);
         end
         if (varre_fim) nfim++;
      end
      idle();
      chk("scan valid count", 32'(nv), 32'd3);
      chk("scan valid mask", 32'(seen), 32'h8005);
      chk("scan fim count", 32'(nfim), 32'd1);

      // Reset in the middle of a scan.
      varre_inicio = 1'b1;
      tick();
      idle();
      repeat (5) tick();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst ocupado", 32'(varre_ocupado), 32'd0);
      chk("rst cheio", 32'(cheio), 32'd0);
      chk("rst ocupacao", 32'(ocupacao), 32'd0);
      chk("rst rd_valid", 32'(rd_valid), 32'd0);
      check_all();
      @(negedge clk);
      reset = 1'b0;
      nfim = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (varre_fim) nfim++;
      end
      chk("rst no fim", 32'(nfim), 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         aloca_req    = 1'($urandom_range(0, 1));
         aloca_dado   = 10'($urandom);
         libera       = ($urandom_range(0, 2) == 0);
         libera_idx   = 4'($urandom);
         wr_en        = ($urandom_range(0, 2) == 0);
         wr_addr      = 4'($urandom);
         wr_data      = 10'($urandom);
         rd_addr      = 4'($urandom);
         varre_inicio = ($urandom_range(0, 19) == 0);
         tick();
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tabela_tiros.md
Name: tabela_tiros

Overview:
- Parametrised shot table; successor to the fixed 16x10 shot RAM.
- Adds per-slot valid bitmap, lowest-free-slot allocation with ack/nack, release by index, in-place update, 1-cycle registered read, and a sequential scan engine that feeds the renderer and collision logic.
- Storage is a register array, so allocation, update, read and scan ports run concurrently.

Parameters:
DATA_W, 10, entry width (default packing {x[3:0], y[3:0], dir[1:0]})
DEPTH, 16, number of shot slots, power of two, 2..64
AW, 4, index width; must equal clog2(DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
aloca_req  in  1  allocate request, sampled each edge
aloca_dado  in  DATA_W  data for new shot
aloca_ack  out  1  1-cycle pulse: allocation done
aloca_nack  out  1  1-cycle pulse: table was full
aloca_idx  out  AW  slot granted; valid with aloca_ack
cheio  out  1  all slots valid (combinational from bitmap)
libera  in  1  release slot
libera_idx  in  AW  slot to release
wr_en  in  1  update existing entry
wr_addr  in  AW  update index
wr_data  in  DATA_W  update data
rd_addr  in  AW  read index
rd_data  out  DATA_W  entry at registered rd_addr
rd_valid  out  1  valid bit of registered rd_addr
varre_inicio  in  1  start scan
varre_ocupado  out  1  scan in progress
varre_valido  out  1  visited slot is valid
varre_idx  out  AW  visited slot index
varre_dado  out  DATA_W  visited slot data
varre_fim  out  1  1-cycle pulse after last slot
ocupacao  out  AW+1  number of valid slots (optional feature)

Behaviour:
- Reset: valid bitmap cleared; rd_addr register, scan pointer, aloca_idx, varre_idx, varre_dado = 0; aloca_ack, aloca_nack, varre_valido, varre_ocupado, varre_fim = 0; FSM = OCIOSO. Data array is not cleared.
- Allocation:
  - aloca_req at edge with cheio=0: lowest-index free slot, per the pre-edge bitmap, is written with aloca_dado and its valid bit set.
  - The following cycle has aloca_ack=1 and aloca_idx=slot.
  - aloca_req with cheio=1: no state change; aloca_nack=1 the following cycle.
  - aloca_req held high allocates on every edge.
- Release: libera sets valid[libera_idx]=0. Releasing a free slot is a no-op.
- Simultaneous allocation and release:
  - The slot being released is not visible to the allocation in the same cycle.
  - Full table plus libera gives nack, with the slot released.
  - Release of the slot just granted cannot occur in the same cycle because the slot was free.
- Update: wr_en writes wr_data only if valid[wr_addr]=1; otherwise ignored. It never changes valid.
  - If alloc and wr_en target the same slot, the slot was free, so wr_en is ignored.
- Read:
  - rd_addr registered each edge.
  - rd_data/rd_valid are combinational from the registered address and current array/bitmap, so reads are write-first: a write or allocate at edge N is visible in the cycle after N.
- Scan FSM:
  - OCIOSO: varre_inicio=1 -> VARRE with ptr=0, varre_ocupado=1.
  - VARRE: each edge registers varre_idx=ptr, varre_dado=ram[ptr], varre_valido=valid[ptr] (pre-edge state), then ptr+1. After registering ptr=DEPTH-1 -> FIM.
  - FIM: varre_fim=1 for one cycle, varre_valido=0, varre_ocupado=0 -> OCIOSO.
  - Output window is DEPTH cycles starting one cycle after the start edge; varre_fim follows in the next cycle.
  - varre_inicio during VARRE/FIM is ignored.
  - Alloc, release and update during a scan take effect; a slot reports the state at the moment it is visited.
- Reset mid-operation: immediate return to reset values; any scan in progress is aborted with no varre_fim.
- Pointer and indices wrap naturally at DEPTH (power of two). No out-of-range index exists.

Optional Feature:
- Macro TABELA_TIROS_OCUPACAO_EN.
- Defined:
  - ocupacao holds a registered valid-slot count, reset 0.
  - Count is +1 on successful alloc, -1 on effective release (slot was valid), net 0 when both occur.
  - Count always equals popcount(valid).
- Undefined: ocupacao tied to 0; no counter logic.

Test Plan:
- Reset, then 3 aloca_req with dados 0x1C0, 0x002, 0x001 on consecutive edges -> acks with idx 0, 1, 2; rd_addr=1 gives rd_data=0x002, rd_valid=1; ocupacao=3.
- libera idx 1, then aloca_req 0x05C -> granted idx 1; rd idx 1 gives 0x05C.
- Fill all 16 slots, then aloca_req -> aloca_nack=1, cheio=1. Same-cycle aloca_req + libera idx 7 -> nack, valid[7]=0, cheio=0, ocupacao=15. Next aloca_req -> idx 7.
- wr_en to free idx 9 with 0x3FF -> rd_data unchanged and rd_valid=0. wr_en to valid idx 0 with 0x0AA -> rd idx 0 gives 0x0AA on the following cycle.
- Slots 0, 2, 15 valid; pulse varre_inicio -> 16 cycles, idx 0..15, varre_valido high only at 0, 2, 15 with matching data; then varre_fim for 1 cycle. A varre_inicio mid-scan is ignored.
- Assert reset at scan cycle 5 -> varre_ocupado=0, no varre_fim, bitmap empty, cheio=0, ocupacao=0.
